// File: rtl/verdict_collector.sv
// Timestamped record FIFO for two monitor output streams, with sticky overflow.
// Optional saturating drop counter compiled in with VERDICT_DROP_CNT_EN.
module verdict_collector #(
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DATA_W-1:0]          output_0,
    input  logic                       output_0_aktv,
    input  logic [DATA_W-1:0]          output_1,
    input  logic                       output_1_aktv,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [TS_W-1:0]            rec_ts,
    output logic [1:0]                 rec_aktv,
    output logic [DATA_W-1:0]          rec_out0,
    output logic [DATA_W-1:0]          rec_out1,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic [15:0]                drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TS_W-1:0]   ts;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic              overflow_q;

    logic [TS_W-1:0]   mem_ts   [DEPTH];
    logic [1:0]        mem_aktv [DEPTH];
    logic [DATA_W-1:0] mem_out0 [DEPTH];
    logic [DATA_W-1:0] mem_out1 [DEPTH];

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Handshake: a record transfers on any cycle where rec_valid and rec_ready are both high;
    // rec_valid never depends on rec_ready, and rec_ready is ignored while rec_valid is low.
    assign capture   = en & (output_0_aktv | output_1_aktv);
    assign full      = (count_q == CW'(DEPTH));
    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid & rec_ready;
    assign push      = capture & (~full | pop);
    assign drop      = capture & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts         <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (en) begin
                ts <= ts + TS_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // Clearing wins over a drop landing in the same cycle.
            if (clr_ovf) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset; payload outputs are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_ts[wr_ptr]   <= ts;
            mem_aktv[wr_ptr] <= {output_1_aktv, output_0_aktv};
            mem_out0[wr_ptr] <= output_0_aktv ? output_0 : '0;
            mem_out1[wr_ptr] <= output_1_aktv ? output_1 : '0;
        end
    end

    assign rec_ts   = mem_ts[rd_ptr];
    assign rec_aktv = mem_aktv[rd_ptr];
    assign rec_out0 = mem_out0[rd_ptr];
    assign rec_out1 = mem_out1[rd_ptr];
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef VERDICT_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst || clr_ovf) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_verdict_collector.sv
// Self-checking bench for verdict_collector: directed table, corner sequences, random run vs queue model.
module tb_verdict_collector;
    localparam int DATA_W = 64;
    localparam int TS_W   = 32;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef VERDICT_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [DATA_W-1:0] output_0 = '0;
    logic              output_0_aktv = 1'b0;
    logic [DATA_W-1:0] output_1 = '0;
    logic              output_1_aktv = 1'b0;
    logic              rec_valid;
    logic              rec_ready = 1'b0;
    logic [TS_W-1:0]   rec_ts;
    logic [1:0]        rec_aktv;
    logic [DATA_W-1:0] rec_out0;
    logic [DATA_W-1:0] rec_out1;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              clr_ovf = 1'b0;
    logic [15:0]       drop_cnt;

    verdict_collector #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .output_0(output_0), .output_0_aktv(output_0_aktv),
        .output_1(output_1), .output_1_aktv(output_1_aktv),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_ts(rec_ts), .rec_aktv(rec_aktv),
        .rec_out0(rec_out0), .rec_out1(rec_out1),
        .count(count), .overflow(overflow),
        .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TS_W-1:0]   ts;
        logic [1:0]        aktv;
        logic [DATA_W-1:0] o0;
        logic [DATA_W-1:0] o1;
    } rec_t;

    rec_t            exp_q[$];
    logic [TS_W-1:0] m_ts;
    logic            m_ovf;
    int              m_drop;
    int              n_cmp;
    int              n_err;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic check_model();
        check("valid", 64'(rec_valid), 64'(exp_q.size() != 0));
        check("count", 64'(count), 64'(exp_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (exp_q.size() != 0) begin
            check("head_ts", 64'(rec_ts), 64'(exp_q[0].ts));
            check("head_aktv", 64'(rec_aktv), 64'(exp_q[0].aktv));
            check("head_out0", rec_out0, exp_q[0].o0);
            check("head_out1", rec_out1, exp_q[0].o1);
        end
    endtask

    // Drive one cycle's inputs, advance the model, then compare away from the active edge.
    task automatic cycle(input logic r, input logic e, input logic a0, input logic [DATA_W-1:0] v0,
                         input logic a1, input logic [DATA_W-1:0] v1, input logic rdy, input logic clr);
        logic full, pop, cap, drp;
        rec_t tmp;
        rst = r; en = e; output_0_aktv = a0; output_0 = v0;
        output_1_aktv = a1; output_1 = v1; rec_ready = rdy; clr_ovf = clr;
        if (r) begin
            exp_q.delete();
            m_ts = '0; m_ovf = 1'b0; m_drop = 0;
        end else begin
            full = (exp_q.size() == DEPTH);
            pop  = (exp_q.size() != 0) && rdy;
            cap  = e && (a0 || a1);
            drp  = 1'b0;
            if (pop) tmp = exp_q.pop_front();
            if (cap) begin
                if (!full || pop) begin
                    tmp.ts = m_ts; tmp.aktv = {a1, a0};
                    tmp.o0 = a0 ? v0 : '0; tmp.o1 = a1 ? v1 : '0;
                    exp_q.push_back(tmp);
                end else begin
                    drp = 1'b1;
                end
            end
            if (clr) begin
                m_ovf = 1'b0; m_drop = 0;
            end else if (drp) begin
                m_ovf = 1'b1;
                if (DROP_EN && m_drop < 65535) m_drop++;
            end
            if (e) m_ts = m_ts + 1;
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic en, a0, a1, rdy;
        logic [DATA_W-1:0] v0, v1;
        logic ev;
        int ecnt;
        logic chk;
        logic [TS_W-1:0] ets;
        logic [1:0] eaktv;
        logic [DATA_W-1:0] eo0, eo1;
    } vec_t;

    vec_t vecs[3];
    logic [TS_W-1:0] saved_ts;

    initial begin
        n_cmp = 0; n_err = 0;
        m_ts = '0; m_ovf = 1'b0; m_drop = 0;

        vecs[0] = '{en:1'b1, a0:1'b1, a1:1'b0, rdy:1'b0, v0:64'd5, v1:64'd99, ev:1'b1, ecnt:1,
                    chk:1'b1, ets:32'd10, eaktv:2'b01, eo0:64'd5, eo1:64'd0};
        vecs[1] = '{en:1'b1, a0:1'b1, a1:1'b1, rdy:1'b1, v0:-64'sd3, v1:64'd7, ev:1'b1, ecnt:1,
                    chk:1'b1, ets:32'd11, eaktv:2'b11, eo0:-64'sd3, eo1:64'd7};
        vecs[2] = '{en:1'b1, a0:1'b0, a1:1'b0, rdy:1'b1, v0:64'd0, v1:64'd0, ev:1'b0, ecnt:0,
                    chk:1'b0, ets:32'd0, eaktv:2'b00, eo0:64'd0, eo1:64'd0};

        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_valid", 64'(rec_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        repeat (10) cycle(0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            cycle(0, vecs[i].en, vecs[i].a0, vecs[i].v0, vecs[i].a1, vecs[i].v1, vecs[i].rdy, 0);
            check($sformatf("vec%0d_valid", i), 64'(rec_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ecnt));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_ts", i), 64'(rec_ts), 64'(vecs[i].ets));
                check($sformatf("vec%0d_aktv", i), 64'(rec_aktv), 64'(vecs[i].eaktv));
                check($sformatf("vec%0d_out0", i), rec_out0, vecs[i].eo0);
                check($sformatf("vec%0d_out1", i), rec_out1, vecs[i].eo1);
            end
        end

        // Ten captures into an eight-deep FIFO with the consumer stalled.
        for (int i = 0; i < 10; i++) cycle(0, 1, 1, 64'(100 + i), 0, 0, 0, 0);
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop_cnt", 64'(drop_cnt), DROP_EN ? 64'd2 : 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", rec_out0, 64'(100 + i));
            cycle(0, 0, 0, 0, 0, 0, 1, 0);
        end
        check("drain_empty", 64'(rec_valid), 64'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        check("clr_ovf", 64'(overflow), 64'd0);

        // Full FIFO: capture with a simultaneous pop is accepted.
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 64'(200 + i), 0, 0, 0, 0);
        cycle(0, 1, 1, 64'd500, 0, 0, 1, 0);
        check("full_swap_count", 64'(count), 64'd8);
        check("full_swap_ovf", 64'(overflow), 64'd0);
        cycle(0, 1, 1, 64'd600, 0, 0, 0, 1);
        check("clr_beats_drop", 64'(overflow), 64'd0);
        check("clr_drop_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("swap_order", rec_out0, (i < 7) ? 64'(201 + i) : 64'd500);
            cycle(0, 0, 0, 0, 0, 0, 1, 0);
        end

        // en low: aktv pulses are ignored, timestamp freezes, draining continues.
        cycle(0, 1, 1, 64'd700, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 64'd701, 0, 0);
        saved_ts = m_ts;
        for (int i = 0; i < 5; i++) cycle(0, 0, i[0], 64'd800, ~i[0], 64'd801, 1, 0);
        check("en_off_drained", 64'(count), 64'd0);
        cycle(0, 1, 1, 64'd900, 0, 0, 0, 0);
        check("en_off_ts_frozen", 64'(rec_ts), 64'(saved_ts));
        cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Reset mid-drain with overflow set and four records pending.
        for (int i = 0; i < 9; i++) cycle(0, 1, 1, 64'(300 + i), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
        check("pre_rst_count", 64'(count), 64'd4);
        check("pre_rst_ovf", 64'(overflow), 64'd1);
        cycle(1, 1, 1, 64'd1, 0, 0, 1, 0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(rec_valid), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        cycle(0, 1, 1, 64'd42, 0, 0, 0, 0);
        check("post_rst_ts", 64'(rec_ts), 64'd0);
        check("post_rst_out0", rec_out0, 64'd42);

        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 8),
                  1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), {$urandom, $urandom},
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
